if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- LEGv8 instruction-fetch unit: the producer side of the control unit's opcode/branch interface.
- Holds the PC and fetches 32-bit words from instruction memory over a req/ack handshake.
- Presents the instruction and its 11-bit opcode to the control unit and datapath over valid/ready.
- Applies the control unit's pcSrc and the sign-extended branch offset when the instruction is accepted, to pick the next PC.

Parameters:
PC_W, 64, width of PC and instruction address
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
run  in  1  fetch enable; 0 parks the unit in IDLE at the next fetch boundary
imem_req  out  1  instruction memory request, registered
imem_addr  out  PC_W  fetch address (current PC), registered
imem_ack  in  1  memory response strobe; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
instr_valid  out  1  instr/opcode/instr_pc valid
instr_ready  in  1  consumer accepts the instruction this cycle
instr  out  32  latched instruction word
opcode  out  11  instr[31:21], combinational from instr register
instr_pc  out  PC_W  address the instruction was fetched from
pc_src  in  1  branch-taken decision from control unit, sampled at accept
br_offset  in  PC_W  sign-extended word offset from sign extender, sampled at accept
instr_count  out  32  number of accepted instructions, wraps

Behaviour:
- Reset (async, immediate):
  - state=IDLE, pc=RESET_PC.
  - imem_req=0, imem_addr=RESET_PC.
  - instr_valid=0, instr=0, instr_pc=RESET_PC, instr_count=0.
  - Reset mid-transaction abandons it; a late imem_ack after reset release is ignored while in IDLE.
- States: IDLE, FETCH, HOLD.
- IDLE:
  - imem_req=0.
  - If run=1 at a clock edge: next state FETCH, imem_req<=1, imem_addr<=pc.
  - The first request appears one cycle after reset release with run=1.
- FETCH:
  - imem_req stays 1 and imem_addr stays stable until imem_ack.
  - imem_ack may arrive in the first cycle req is high (zero wait); any number of wait cycles is allowed; no timeout.
  - On imem_ack: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, imem_req<=0, next state HOLD.
  - run=0 during FETCH does not abort the outstanding request.
- HOLD:
  - instr_valid=1; instr, instr_pc and opcode are stable until accepted.
  - Accept = instr_valid & instr_ready. On accept:
    - next pc = pc_src ? instr_pc + (br_offset << 2) : instr_pc + 4
    - instr_valid<=0, instr_count<=instr_count+1.
    - If run=1: next state FETCH, imem_req<=1, imem_addr<=next pc.
    - If run=0: next state IDLE, pc is still updated.
  - Without instr_ready, the unit stays in HOLD indefinitely.
- Latency:
  - ack at edge N -> instr_valid high after edge N.
  - accept at edge M -> new imem_req high after edge M.
  - Minimum 2 cycles per instruction with zero-wait memory (one bubble, by design).
- Arithmetic:
  - All PC math is modulo 2^PC_W; wrap past all-ones is silent.
  - br_offset is two's complement; negative offsets move backwards.
  - The shift by 2 keeps the PC word-aligned; low 2 bits are always 0 provided RESET_PC is aligned.
- imem_ack outside FETCH is ignored.
- pc_src and br_offset are don't-care except in the accept cycle.
- instr_count wraps 0xFFFFFFFF -> 0.

Decomposition:
- Shared package (if_pkg), used by the control unit and the datapath:
  - state encoding: IDLE=2'd0, FETCH=2'd1, HOLD=2'd2.
  - INSTR_W=32, OPCODE_W=11.
  - opcode field positions: [31:21].
  - PC increment constant 4.
- One natural sub-module: next_pc_calc, a combinational adder/mux taking instr_pc, pc_src and br_offset and producing the next PC.
- FSM, handshake registers and counter live in the top.

Test Plan:
- Reset then run=1, zero-wait memory returning 0x8B020020 at addr 0, instr_ready=1 -> imem_req 1 cycle after reset release at addr 0; instr_valid next cycle with opcode=0x458; next request at addr 4; instr_count=1.
- Memory inserts 3 wait cycles at addr 8 -> imem_req/imem_addr held stable for 4 cycles; exactly one instr_valid pulse with correct word.
- Accept at instr_pc=0x10 with pc_src=1, br_offset=-2 -> next imem_addr=0x08. Repeat with pc_src=0, br_offset=100 -> next imem_addr=0x14.
- instr_ready held low 5 cycles in HOLD -> instr and opcode stable, no new imem_req, instr_count unchanged.
- rst asserted while imem_req=1 in FETCH, ack arrives 1 cycle after release -> outputs return to reset values immediately; ack ignored; fresh fetch at RESET_PC.
- instr_pc=0xFFFF_FFFF_FFFF_FFFC, pc_src=0 -> next addr 0. run=0 at accept -> state IDLE, no req until run=1, then fetch resumes at the updated PC.

Source files
------------

// File: rtl/if_pkg.sv
// if_pkg: shared fetch-side types and constants (state encoding, widths, opcode field, PC step)
package if_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;
  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 11;
  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 21;
  localparam int PC_INC   = 4;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC select (branch target or sequential)
// ports: instr_pc (accepted instruction address), pc_src (branch taken),
//        br_offset (sign-extended word offset), next_pc (result, modulo 2^PC_W)
module next_pc_calc
  import if_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic [PC_W-1:0] instr_pc,
  input  logic            pc_src,
  input  logic [PC_W-1:0] br_offset,
  output logic [PC_W-1:0] next_pc
);
  assign next_pc = instr_pc + (pc_src ? {br_offset[PC_W-3:0], 2'b00} : PC_W'(PC_INC));
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: LEGv8 instruction fetch; PC, imem req/ack, instr valid/ready, branch redirect
// ports: clk/rst (async high); run enables fetch; imem_req/imem_addr/imem_ack/imem_rdata memory side;
//        instr_valid/instr_ready/instr/opcode/instr_pc consumer side; pc_src/br_offset sampled at accept;
//        instr_count counts accepted instructions
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [INSTR_W-1:0]  instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [PC_W-1:0]     instr_pc,
  input  logic                pc_src,
  input  logic [PC_W-1:0]     br_offset,
  output logic [31:0]         instr_count
);
  state_t state, state_n;
  logic [PC_W-1:0] pc, next_pc;
  logic accept, launch;
  assign accept = instr_valid & instr_ready;
  assign opcode = instr[OPC_HI:OPC_LO];
  next_pc_calc #(.PC_W(PC_W)) u_next_pc (
    .instr_pc (instr_pc),
    .pc_src   (pc_src),
    .br_offset(br_offset),
    .next_pc  (next_pc)
  );
  always_comb
    state_n = (state == IDLE)  ? (run ? FETCH : IDLE) :
              (state == FETCH) ? (imem_ack ? HOLD : FETCH) :
              (state == HOLD)  ? (accept ? (run ? FETCH : IDLE) : HOLD) : IDLE;
  // a new request starts whenever we enter FETCH from IDLE or HOLD
  assign launch = (state_n == FETCH) && (state != FETCH);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= RESET_PC;
      instr_count <= '0;
    end else begin
      if (launch) begin
        imem_req  <= 1'b1;
        imem_addr <= (state == HOLD) ? next_pc : pc;
      end
      if (state == FETCH && imem_ack) begin
        instr       <= imem_rdata;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
        imem_req    <= 1'b0;
      end
      if (accept) begin
        pc          <= next_pc;
        instr_valid <= 1'b0;
        instr_count <= instr_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed + randomized check of if_fetch_unit against a transaction-level model
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [10:0] opcode;
  logic [63:0] instr_pc;
  logic        pc_src = 1'b0;
  logic [63:0] br_offset = '0;
  logic [31:0] instr_count;

  if_fetch_unit #(.PC_W(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .opcode(opcode),
    .instr_pc(instr_pc), .pc_src(pc_src), .br_offset(br_offset), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model: outstanding request, presented instruction, PC and count
  logic        m_req, m_valid;
  logic [63:0] m_addr, m_ipc, m_pc;
  logic [31:0] m_instr, m_count;
  int          wcnt;
  bit          rnd_wait = 0;
  int          dflt_wait = 0;
  bit          force_ack = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[31:0];
    return (a == 64'h0) ? 32'h8B020020 : (lo * 32'h9E3779B1) ^ 32'h5A5A0F0F ^ a[63:32];
  endfunction

  function automatic int wait_for(input logic [63:0] a);
    return rnd_wait ? int'($urandom_range(0, 3)) : (a == 64'h8 ? 3 : dflt_wait);
  endfunction

  task automatic model_reset();
    m_req = 0; m_valid = 0; m_addr = 0; m_ipc = 0; m_pc = 0; m_instr = 0; m_count = 0; wcnt = 0;
  endtask

  task automatic compare_all();
    chk("req", imem_req, m_req);
    chk("addr", imem_addr, m_addr);
    chk("valid", instr_valid, m_valid);
    chk("instr", instr, m_instr);
    chk("opcode", opcode, m_instr[31:21]);
    chk("instr_pc", instr_pc, m_ipc);
    chk("count", instr_count, m_count);
  endtask

  task automatic step(input logic r, input logic rd, input logic s, input logic [63:0] o);
    logic [63:0] npc;
    run = r; instr_ready = rd; pc_src = s; br_offset = o;
    imem_ack = force_ack | (m_req && wcnt == 0);
    imem_rdata = imem_ack ? mem_word(m_addr) : $urandom;
    @(posedge clk);
    if (m_req && imem_ack) begin
      m_valid = 1; m_instr = mem_word(m_addr); m_ipc = m_addr; m_req = 0;
    end else if (m_req) begin
      wcnt--;
    end else if (m_valid && rd) begin
      npc = s ? m_ipc + o * 4 : m_ipc + 4;
      m_pc = npc; m_valid = 0; m_count++;
      if (r) begin m_req = 1; m_addr = npc; wcnt = wait_for(npc); end
    end else if (!m_valid && r) begin
      m_req = 1; m_addr = m_pc; wcnt = wait_for(m_pc);
    end
    force_ack = 0;
    #1;
    imem_ack = 0;
    compare_all();
  endtask

  task automatic wait_valid(output int n);
    int k;
    n = int'(imem_req);
    k = 0;
    while (!instr_valid && k < 50) begin
      step(1, 0, 0, 0);
      if (imem_req) n++;
      k++;
    end
    if (k == 50) chk("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic fetch_accept(input logic s, input logic [63:0] o, input logic r);
    int n;
    wait_valid(n);
    step(r, 1, s, o);
  endtask

  initial begin
    int n;
    logic [31:0] s_instr;
    logic [31:0] s_cnt;
    logic signed [63:0] t;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 0;
    // first fetch at 0, zero-wait memory
    step(1, 0, 0, 0);
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);
    step(1, 0, 0, 0);
    chk("opc458", opcode, 11'h458);
    step(1, 1, 0, 0);
    chk("next_addr4", imem_addr, 64'h4);
    chk("count1", instr_count, 1);
    // 4 accepted, 8 fetched with 3 wait cycles
    fetch_accept(0, 0, 1);
    wait_valid(n);
    chk("req_hold8", 64'(n), 4);
    step(1, 1, 0, 0);
    fetch_accept(0, 0, 1);
    fetch_accept(1, -64'sd2, 1);
    chk("br_back", imem_addr, 64'h8);
    fetch_accept(0, 0, 1);
    fetch_accept(0, 0, 1);
    fetch_accept(0, 64'd100, 1);
    chk("seq14", imem_addr, 64'h14);
    // stall in HOLD
    wait_valid(n);
    s_instr = instr;
    s_cnt = instr_count;
    repeat (5) step(1, 0, 0, 0);
    chk("hold_instr", instr, s_instr);
    chk("hold_opc", opcode, s_instr[31:21]);
    chk("hold_req", imem_req, 0);
    chk("hold_cnt", instr_count, s_cnt);
    dflt_wait = 6;
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("mid_req", imem_req, 1);
    // reset mid-fetch, late ack after release
    rst = 1;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    rst = 0;
    dflt_wait = 0;
    force_ack = 1;
    step(0, 0, 0, 0);
    chk("late_ack_valid", instr_valid, 0);
    step(1, 0, 0, 0);
    chk("refetch0", imem_addr, 0);
    // branch to the top of the address space, then wrap sequentially with run=0
    wait_valid(n);
    t = -64'sd4 - $signed(m_ipc);
    step(1, 1, 1, 64'(t >>> 2));
    chk("top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_valid(n);
    chk("top_ipc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    chk("idle_req", imem_req, 0);
    step(1, 0, 0, 0);
    chk("wrap_addr", imem_addr, 0);
    chk("wrap_req", imem_req, 1);
    // randomized traffic
    rnd_wait = 1;
    for (int i = 0; i < 400; i++) begin
      int so;
      so = int'($urandom_range(0, 63)) - 32;
      step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           64'(signed'(64'(so))));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
